// File: rtl/reg_file_sb_pkg.sv
// Shared defaults and elaboration-time helpers for the scoreboarded register file.
package reg_file_sb_pkg;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_NUM_REGS = 32;

  // Ceiling log2 with a floor of 1 so a single-bit index is still a legal vector.
  function automatic int clog2(input int n);
    int r;
    r = 32'sd1;
    while ((32'sd1 << r) < n) r = r + 32'sd1;
    return r;
  endfunction

  function automatic logic idxValid(input int idx, input int numRegs);
    return (idx > 32'sd0) && (idx < numRegs);
  endfunction

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-producer scoreboard: one pending bit per register plus a registered
// count of pending entries, with per-read-port hazard flags.
module reg_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int AW       = clog2(NUM_REGS),
  parameter int CW       = clog2(NUM_REGS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RegWrite,
  input  logic [AW-1:0]        WriteRegister,
  input  logic                 Reserve,
  input  logic [AW-1:0]        ReserveRegister,
  input  logic [NUM_RD*AW-1:0] ReadRegister,
  output logic [NUM_RD-1:0]    RegBusy,
  output logic [CW-1:0]        BusyCount
);

  localparam int DEPTH = 1 << AW;

  logic [DEPTH-1:0] pending_r;
  logic [DEPTH-1:0] pendingNext_s;
  logic [CW-1:0]    busyCount_r;
  logic [CW-1:0]    countNext_s;
  logic             writeValid_s;
  logic             reserveValid_s;
  logic             countUp_s;
  logic             countDown_s;

  // Qualify write and reserve requests against the architectural register range.
  always_comb begin
    writeValid_s   = RegWrite && idxValid(int'(WriteRegister), NUM_REGS);
    reserveValid_s = Reserve && idxValid(int'(ReserveRegister), NUM_REGS);
  end

  // Next pending vector and count delta; a same-index reserve overrides the write clear.
  always_comb begin
    pendingNext_s = pending_r;
    countUp_s     = 1'b0;
    countDown_s   = 1'b0;
    if (writeValid_s) begin
      pendingNext_s[WriteRegister] = 1'b0;
      countDown_s                  = pending_r[WriteRegister];
    end else begin
      countDown_s = 1'b0;
    end
    if (reserveValid_s) begin
      pendingNext_s[ReserveRegister] = 1'b1;
      countUp_s                      = ~pending_r[ReserveRegister];
      if (writeValid_s && (WriteRegister == ReserveRegister)) begin
        countDown_s = 1'b0;
      end else begin
        countDown_s = countDown_s;
      end
    end else begin
      countUp_s = 1'b0;
    end
  end

  // Count moves by at most one per edge since at most one bit sets and one clears.
  always_comb begin
    case ({countUp_s, countDown_s})
      2'b10:   countNext_s = busyCount_r + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   countNext_s = busyCount_r - {{(CW-1){1'b0}}, 1'b1};
      default: countNext_s = busyCount_r;
    endcase
  end

  // Scoreboard state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r   <= {DEPTH{1'b0}};
      busyCount_r <= {CW{1'b0}};
    end else begin
      pending_r   <= pendingNext_s;
      busyCount_r <= countNext_s;
    end
  end

  // Hazard flag per read port; a forwarded write hides the stale pending bit.
  always_comb begin
    RegBusy = {NUM_RD{1'b0}};
    for (int i = 0; i < NUM_RD; i++) begin
      if (idxValid(int'(ReadRegister[i*AW +: AW]), NUM_REGS)) begin
        RegBusy[i] = pending_r[ReadRegister[i*AW +: AW]] &&
                     !((BYPASS != 32'sd0) && writeValid_s &&
                       (WriteRegister == ReadRegister[i*AW +: AW]));
      end else begin
        RegBusy[i] = 1'b0;
      end
    end
  end

  assign BusyCount = busyCount_r;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read, single-write register file with zero register, optional write
// forwarding and an attached pending-producer scoreboard.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  localparam int AW      = clog2(NUM_REGS),
  localparam int CW      = clog2(NUM_REGS + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     RegWrite,
  input  logic [AW-1:0]            WriteRegister,
  input  logic [DATA_W-1:0]        WriteData,
  input  logic [NUM_RD*AW-1:0]     ReadRegister,
  output logic [NUM_RD*DATA_W-1:0] ReadData,
  input  logic                     Reserve,
  input  logic [AW-1:0]            ReserveRegister,
  output logic [NUM_RD-1:0]        RegBusy,
  output logic [CW-1:0]            BusyCount
);

  localparam int DEPTH = 1 << AW;

  // Entries at and above NUM_REGS are never written and never read out.
  logic [DATA_W-1:0] regMem_r [DEPTH];
  logic              writeValid_s;

  always_comb begin
    writeValid_s = RegWrite && idxValid(int'(WriteRegister), NUM_REGS);
  end

  // Register storage; entry 0 is excluded by the write qualifier.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        regMem_r[r] <= {DATA_W{1'b0}};
      end
    end else if (writeValid_s) begin
      regMem_r[WriteRegister] <= WriteData;
    end
  end

  // Independent read ports with range check, reset masking and optional forwarding.
  always_comb begin
    ReadData = {(NUM_RD*DATA_W){1'b0}};
    for (int i = 0; i < NUM_RD; i++) begin
      if (reset) begin
        ReadData[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end else if (!idxValid(int'(ReadRegister[i*AW +: AW]), NUM_REGS)) begin
        ReadData[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end else if ((BYPASS != 32'sd0) && writeValid_s &&
                   (WriteRegister == ReadRegister[i*AW +: AW])) begin
        ReadData[i*DATA_W +: DATA_W] = WriteData;
      end else begin
        ReadData[i*DATA_W +: DATA_W] = regMem_r[ReadRegister[i*AW +: AW]];
      end
    end
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .BYPASS   (BYPASS),
    .AW       (AW),
    .CW       (CW)
  ) uScoreboard (
    .clk             (clk),
    .reset           (reset),
    .RegWrite        (RegWrite),
    .WriteRegister   (WriteRegister),
    .Reserve         (Reserve),
    .ReserveRegister (ReserveRegister),
    .ReadRegister    (ReadRegister),
    .RegBusy         (RegBusy),
    .BusyCount       (BusyCount)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a forwarding 32-entry instance and a non-forwarding
// 24-entry instance share one stimulus stream and one reference model.
module tb_reg_file_sb;

  localparam int NREGS [2] = '{32, 24};
  localparam int BYP   [2] = '{1, 0};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [9:0]  ReadRegister;
  logic        Reserve;
  logic [4:0]  ReserveRegister;
  logic [63:0] rdA, rdB;
  logic [1:0]  busyA, busyB;
  logic [5:0]  cntA;
  logic [4:0]  cntB;

  logic [31:0] mem  [2][32];
  logic        pend [2][32];
  int          nVec = 0;
  int          nMis = 0;
  logic        checkEn = 1'b0;

  reg_file_sb #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .BYPASS(1)) dutA (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .ReadRegister(ReadRegister), .ReadData(rdA),
    .Reserve(Reserve), .ReserveRegister(ReserveRegister), .RegBusy(busyA),
    .BusyCount(cntA));

  reg_file_sb #(.DATA_W(32), .NUM_REGS(24), .NUM_RD(2), .BYPASS(0)) dutB (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .ReadRegister(ReadRegister), .ReadData(rdB),
    .Reserve(Reserve), .ReserveRegister(ReserveRegister), .RegBusy(busyB),
    .BusyCount(cntB));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference state: architectural registers and pending flags per instance.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 2; c++)
        for (int r = 0; r < 32; r++) begin
          mem[c][r]  <= 32'h0;
          pend[c][r] <= 1'b0;
        end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (RegWrite && WriteRegister != 5'd0 && int'(WriteRegister) < NREGS[c]) begin
          mem[c][WriteRegister]  <= WriteData;
          pend[c][WriteRegister] <= 1'b0;
        end
        if (Reserve && ReserveRegister != 5'd0 && int'(ReserveRegister) < NREGS[c])
          pend[c][ReserveRegister] <= 1'b1;
      end
    end
  end

  function automatic logic [31:0] expRead(input int c, input int idx);
    if (reset || idx == 0 || idx >= NREGS[c]) return 32'h0;
    if (BYP[c] == 1 && RegWrite && int'(WriteRegister) == idx) return WriteData;
    return mem[c][idx];
  endfunction

  function automatic logic expBusy(input int c, input int idx);
    if (reset || idx == 0 || idx >= NREGS[c]) return 1'b0;
    if (BYP[c] == 1 && RegWrite && int'(WriteRegister) == idx) return 1'b0;
    return pend[c][idx];
  endfunction

  function automatic int expCount(input int c);
    int n;
    n = 0;
    for (int r = 0; r < 32; r++) if (pend[c][r]) n++;
    return n;
  endfunction

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int p = 0; p < 2; p++) begin : portChk
        int idx;
        idx = int'(ReadRegister[p*5 +: 5]);
        check("modelRdA", 64'(rdA[p*32 +: 32]), 64'(expRead(0, idx)));
        check("modelRdB", 64'(rdB[p*32 +: 32]), 64'(expRead(1, idx)));
        check("modelBusyA", 64'(busyA[p]), 64'(expBusy(0, idx)));
        check("modelBusyB", 64'(busyB[p]), 64'(expBusy(1, idx)));
      end
      check("modelCntA", 64'(cntA), 64'(expCount(0)));
      check("modelCntB", 64'(cntB), 64'(expCount(1)));
    end
  end

  task automatic setIn(input logic we, input int wr, input logic [31:0] wd,
                       input logic rsv, input int rr, input int r0, input int r1);
    RegWrite        = we;
    WriteRegister   = 5'(wr);
    WriteData       = wd;
    Reserve         = rsv;
    ReserveRegister = 5'(rr);
    ReadRegister    = {5'(r1), 5'(r0)};
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    setIn(1'b0, 0, 32'h0, 1'b0, 0, 5, 0);
    #1 reset = 1'b1;
    #2;
    check("rstRdA", rdA, 64'h0);
    check("rstCntA", 64'(cntA), 64'd0);
    check("rstBusyA", 64'(busyA), 64'd0);
    #4 reset = 1'b0;
    checkEn = 1'b1;
    tick;

    // Write then read back on both ports.
    setIn(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 5, 5);
    tick;
    setIn(1'b0, 0, 32'h0, 1'b0, 0, 5, 5);
    #1;
    check("r5BothA", rdA, 64'hDEADBEEF_DEADBEEF);
    check("r5BothB", rdB, 64'hDEADBEEF_DEADBEEF);
    check("r5BusyA", 64'(busyA), 64'd0);
    tick;

    // Register zero ignores writes and reserves.
    setIn(1'b1, 0, 32'h12345678, 1'b0, 0, 0, 0);
    tick;
    setIn(1'b0, 0, 32'h0, 1'b1, 0, 0, 0);
    #1 check("r0Read", rdA, 64'h0);
    tick;
    setIn(1'b0, 0, 32'h0, 1'b0, 0, 0, 0);
    #1 check("r0Cnt", 64'(cntA), 64'd0);

    // Forwarding on A, stored value on B until the edge.
    setIn(1'b1, 7, 32'hA5A5A5A5, 1'b0, 0, 7, 5);
    #1;
    check("bypA", 64'(rdA[31:0]), 64'hA5A5A5A5);
    check("noBypB", 64'(rdB[31:0]), 64'h0);
    tick;
    setIn(1'b0, 0, 32'h0, 1'b0, 0, 7, 7);
    #1 check("afterEdgeB", rdB, 64'hA5A5A5A5_A5A5A5A5);

    // Scoreboard: reserve, write+reserve same index, plain write.
    setIn(1'b0, 0, 32'h0, 1'b1, 3, 3, 5);
    tick;
    setIn(1'b0, 0, 32'h0, 1'b0, 0, 3, 5);
    #1;
    check("rsvBusyA", 64'(busyA), 64'b01);
    check("rsvCntA", 64'(cntA), 64'd1);
    setIn(1'b1, 3, 32'h33, 1'b1, 3, 3, 0);
    #1;
    check("fwdHideBusyA", 64'(busyA[0]), 64'd0);
    check("noFwdBusyB", 64'(busyB[0]), 64'd1);
    tick;
    setIn(1'b0, 0, 32'h0, 1'b0, 0, 3, 3);
    #1;
    check("wrRsvBusyA", 64'(busyA), 64'b11);
    check("wrRsvCntA", 64'(cntA), 64'd1);
    check("wrRsvDataA", 64'(rdA[31:0]), 64'h33);
    setIn(1'b1, 3, 32'h44, 1'b0, 0, 3, 3);
    tick;
    setIn(1'b0, 0, 32'h0, 1'b0, 0, 3, 3);
    #1;
    check("clrBusyA", 64'(busyA), 64'd0);
    check("clrCntA", 64'(cntA), 64'd0);
    check("clrCntB", 64'(cntB), 64'd0);

    // Out-of-range index on the 24-entry instance.
    setIn(1'b1, 30, 32'hCAFEF00D, 1'b0, 0, 30, 30);
    #1 check("oorBypB", rdB, 64'h0);
    tick;
    setIn(1'b0, 0, 32'h0, 1'b1, 30, 30, 30);
    #1;
    check("oorRdB", rdB, 64'h0);
    check("oorBusyB", 64'(busyB), 64'd0);
    check("inRangeA", 64'(rdA[31:0]), 64'hCAFEF00D);
    tick;
    setIn(1'b1, 30, 32'h1, 1'b0, 0, 30, 1);
    #1;
    check("oorCntB", 64'(cntB), 64'd0);
    check("rsv30CntA", 64'(cntA), 64'd1);
    tick;

    // Three reserves, then asynchronous reset between edges.
    setIn(1'b0, 0, 32'h0, 1'b1, 1, 1, 2);
    tick;
    setIn(1'b0, 0, 32'h0, 1'b1, 2, 1, 2);
    tick;
    setIn(1'b0, 0, 32'h0, 1'b1, 4, 4, 2);
    tick;
    setIn(1'b1, 9, 32'h77, 1'b0, 0, 9, 5);
    #1;
    check("threeCntA", 64'(cntA), 64'd3);
    check("threeCntB", 64'(cntB), 64'd3);
    check("preRstByp", 64'(rdA[31:0]), 64'h77);
    reset = 1'b1;
    #1;
    check("asyncCntA", 64'(cntA), 64'd0);
    check("asyncCntB", 64'(cntB), 64'd0);
    check("asyncRdA", rdA, 64'h0);
    check("asyncRdB", rdB, 64'h0);
    tick;
    reset = 1'b0;
    setIn(1'b0, 0, 32'h0, 1'b0, 0, 9, 5);
    #1 check("rstIgnoredWr", rdA, 64'h0);
    tick;

    // Mixed traffic checked by the model alone.
    for (int i = 1; i <= 12; i++) begin
      setIn(1'b1, (i * 7) % 32, 32'h1000_0000 + 32'(i) * 32'h0101_0101,
            1'(i % 2), (i * 3) % 32, (i * 7) % 32, ((i - 1) * 7) % 32);
      tick;
    end
    setIn(1'b0, 0, 32'h0, 1'b0, 0, 21, 28);
    tick;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
